// File: rtl/t48_timer_counter.sv
// ---------------------------------------------------------------------------
// t48_timer_counter
//   8-bit timer / event counter of the T48 core.
//   Timer mode: advances once every 2**PRE_W machine cycles, paced by the
//   machine-state strobe coming from the clock controller.
//   Counter mode: advances once per machine cycle in which at least one
//   falling edge was seen on T1.
//   On an FF->00 wrap it sets a sticky flag and emits a one-clock pulse.
//
// Ports
//   clk_i          system clock
//   res_i          asynchronous active-low reset
//   en_clk_i       machine-state enable, one clk_i per machine state
//   mstate_i[2:0]  current machine state (0..4 = MSTATE1..MSTATE5)
//   t1_i           T1 pin, already synchronised to clk_i
//   data_i[7:0]    load value for write_timer_i
//   write_timer_i  load data_i into the timer
//   start_timer_i  enter timer mode, prescaler cleared
//   start_cnt_i    enter counter mode, prescaler kept
//   stop_tcnt_i    stop counting
//   clear_flag_i   clear the sticky timer flag
//   data_o[7:0]    current timer value
//   timer_flag_o   sticky overflow flag
//   overflow_o     overflow pulse, one clk_i cycle
// ---------------------------------------------------------------------------
// Mode FSM
//   state       | meaning
//   ST_STOPPED  | nothing advances; prescaler held
//   ST_TIMER    | prescaler advances at TICK_STATE, timer on prescaler wrap
//   ST_COUNTER  | timer advances at TICK_STATE if a T1 falling edge was seen
// ---------------------------------------------------------------------------
module t48_timer_counter #(
  parameter int unsigned PRE_W      = 5,
  parameter logic [2:0]  TICK_STATE = 3'b010
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       en_clk_i,
  input  logic [2:0] mstate_i,
  input  logic       t1_i,
  input  logic [7:0] data_i,
  input  logic       write_timer_i,
  input  logic       start_timer_i,
  input  logic       start_cnt_i,
  input  logic       stop_tcnt_i,
  input  logic       clear_flag_i,
  output logic [7:0] data_o,
  output logic       timer_flag_o,
  output logic       overflow_o
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_TIMER   = 2'd1,
    ST_COUNTER = 2'd2
  } mode_t;

  mode_t            r_mode, w_mode_nxt;
  logic [PRE_W-1:0] r_prescaler, w_prescaler_nxt;
  logic [7:0]       r_timer, w_timer_nxt;
  logic             r_t1_q;
  logic             r_edge_pend, w_edge_pend_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             w_tick;
  logic             w_fall;
  logic             w_inc;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_mode      <= ST_STOPPED;
      r_prescaler <= '0;
      r_timer     <= 8'h00;
      r_t1_q      <= 1'b0;
      r_edge_pend <= 1'b0;
      r_flag      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      // overflow pulse is re-evaluated on every clk_i so it lasts one clock
      r_overflow <= w_overflow_nxt;
      if (en_clk_i) begin
        r_mode      <= w_mode_nxt;
        r_prescaler <= w_prescaler_nxt;
        r_timer     <= w_timer_nxt;
        r_t1_q      <= t1_i;
        r_edge_pend <= w_edge_pend_nxt;
        r_flag      <= w_flag_nxt;
      end
    end
  end

  always_comb begin
    w_mode_nxt      = r_mode;
    w_prescaler_nxt = r_prescaler;
    w_timer_nxt     = r_timer;
    w_edge_pend_nxt = r_edge_pend;
    w_flag_nxt      = r_flag;
    w_overflow_nxt  = 1'b0;
    w_inc           = 1'b0;
    w_tick          = en_clk_i && (mstate_i == TICK_STATE);
    w_fall          = r_t1_q & ~t1_i;

    if (en_clk_i) begin
      // advance under the mode held at the start of this machine state;
      // commands below only change what happens from the next state on
      case (r_mode)
        ST_TIMER: begin
          if (w_tick) begin
            w_prescaler_nxt = r_prescaler + 1'b1;
            w_inc           = &r_prescaler;
          end
        end
        ST_COUNTER: begin
          if (w_tick) begin
            // an edge arriving in the tick state itself is counted now
            w_inc           = r_edge_pend | w_fall;
            w_edge_pend_nxt = 1'b0;
          end else if (w_fall) begin
            w_edge_pend_nxt = 1'b1;
          end
        end
        default: ;
      endcase

      // a load discards a coincident increment and its overflow
      if (write_timer_i) begin
        w_timer_nxt = data_i;
      end else if (w_inc) begin
        w_timer_nxt    = r_timer + 8'd1;
        w_overflow_nxt = &r_timer;
      end

      if (w_overflow_nxt) begin
        w_flag_nxt = 1'b1;
      end else if (clear_flag_i) begin
        w_flag_nxt = 1'b0;
      end

      if (stop_tcnt_i) begin
        w_mode_nxt      = ST_STOPPED;
        w_edge_pend_nxt = 1'b0;
      end else if (start_timer_i) begin
        w_mode_nxt      = ST_TIMER;
        w_prescaler_nxt = '0;
      end else if (start_cnt_i) begin
        w_mode_nxt = ST_COUNTER;
      end
    end
  end

  assign data_o       = r_timer;
  assign timer_flag_o = r_flag;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_t48_timer_counter.sv
module tb_t48_timer_counter;

  logic       clk_i = 1'b0;
  logic       res_i;
  logic       en_clk_i;
  logic [2:0] mstate_i;
  logic       t1_i;
  logic [7:0] data_i;
  logic       write_timer_i;
  logic       start_timer_i;
  logic       start_cnt_i;
  logic       stop_tcnt_i;
  logic       clear_flag_i;
  logic [7:0] data_o;
  logic       timer_flag_o;
  logic       overflow_o;

  t48_timer_counter dut (
    .clk_i         (clk_i),
    .res_i         (res_i),
    .en_clk_i      (en_clk_i),
    .mstate_i      (mstate_i),
    .t1_i          (t1_i),
    .data_i        (data_i),
    .write_timer_i (write_timer_i),
    .start_timer_i (start_timer_i),
    .start_cnt_i   (start_cnt_i),
    .stop_tcnt_i   (stop_tcnt_i),
    .clear_flag_i  (clear_flag_i),
    .data_o        (data_o),
    .timer_flag_o  (timer_flag_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_seen = 0;

  // reference model: mode 0=stopped 1=timer 2=counter
  int m_mode, m_pre, m_tmr, m_edges;
  bit m_t1q, m_flag, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_tmr = 0; m_edges = 0;
    m_t1q = 0; m_flag = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit inc;
    bit ovf;
    inc = 0;
    ovf = 0;
    if (en_clk_i) begin
      if (m_mode == 1 && mstate_i == 3'd2) begin
        if (m_pre + 1 == 32) inc = 1;
        m_pre = (m_pre + 1) % 32;
      end
      if (m_mode == 2) begin
        if (m_t1q && !t1_i) m_edges = m_edges + 1;
        if (mstate_i == 3'd2) begin
          if (m_edges > 0) inc = 1;
          m_edges = 0;
        end
      end
      if (write_timer_i) m_tmr = int'(data_i);
      else if (inc) begin
        if (m_tmr == 255) ovf = 1;
        m_tmr = (m_tmr + 1) % 256;
      end
      if (ovf) m_flag = 1;
      else if (clear_flag_i) m_flag = 0;
      if (stop_tcnt_i) begin m_mode = 0; m_edges = 0; end
      else if (start_timer_i) begin m_mode = 1; m_pre = 0; end
      else if (start_cnt_i) m_mode = 2;
      m_t1q = t1_i;
    end
    m_ovf = ovf;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_i);
    #1;
    chk("model data_o", int'(data_o), m_tmr);
    chk("model timer_flag_o", int'(timer_flag_o), int'(m_flag));
    chk("model overflow_o", int'(overflow_o), int'(m_ovf));
    if (overflow_o) ovf_seen++;
    write_timer_i = 0; start_timer_i = 0; start_cnt_i = 0;
    stop_tcnt_i = 0; clear_flag_i = 0;
  endtask

  task automatic st1(input logic [2:0] ms);
    en_clk_i = 1; mstate_i = ms; step();
  endtask

  task automatic mcyc_t1(input logic [4:0] pat);
    for (int s = 0; s < 5; s++) begin
      t1_i = pat[s];
      st1(3'(s));
    end
  endtask

  task automatic mcycles(input int n);
    for (int k = 0; k < n; k++) mcyc_t1(5'b00000);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] ms;
    logic       t1;
    logic [7:0] d;
    logic       wr, st, sc, sp, clr;
    logic [7:0] e_d;
    logic       e_f, e_o;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic en, input logic [2:0] ms, input logic t1,
                      input logic [7:0] d, input logic wr, input logic st,
                      input logic sc, input logic sp, input logic clr,
                      input logic [7:0] e_d, input logic e_f, input logic e_o);
    vec_t v;
    v.en = en; v.ms = ms; v.t1 = t1; v.d = d; v.wr = wr; v.st = st;
    v.sc = sc; v.sp = sp; v.clr = clr; v.e_d = e_d; v.e_f = e_f; v.e_o = e_o;
    vecs.push_back(v);
  endtask

  initial begin
    int ms;
    res_i = 0; en_clk_i = 0; mstate_i = 0; t1_i = 0; data_i = 0;
    write_timer_i = 0; start_timer_i = 0; start_cnt_i = 0;
    stop_tcnt_i = 0; clear_flag_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3;
    chk("reset data_o", int'(data_o), 0);
    chk("reset flag", int'(timer_flag_o), 0);
    chk("reset overflow", int'(overflow_o), 0);
    res_i = 1;

    //   en    ms    t1    d      wr    st    sc    sp    clr   e_d    e_f   e_o
    addv(1'b1, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    addv(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    addv(1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    addv(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    addv(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    addv(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    addv(1'b0, 3'd0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    addv(1'b1, 3'd0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    addv(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      en_clk_i = vecs[i].en; mstate_i = vecs[i].ms; t1_i = vecs[i].t1;
      data_i = vecs[i].d; write_timer_i = vecs[i].wr; start_timer_i = vecs[i].st;
      start_cnt_i = vecs[i].sc; stop_tcnt_i = vecs[i].sp; clear_flag_i = vecs[i].clr;
      step();
      chk($sformatf("vec%0d data_o", i), int'(data_o), int'(vecs[i].e_d));
      chk($sformatf("vec%0d flag", i), int'(timer_flag_o), int'(vecs[i].e_f));
      chk($sformatf("vec%0d overflow", i), int'(overflow_o), int'(vecs[i].e_o));
    end

    // timer mode from 0xFE across 64 machine cycles
    t1_i = 0; data_i = 8'hFE; write_timer_i = 1; st1(3'd3);
    start_timer_i = 1; st1(3'd4);
    ovf_seen = 0;
    mcycles(31); chk("timer 31 cycles", int'(data_o), 8'hFE);
    mcycles(1);  chk("timer 32 cycles", int'(data_o), 8'hFF);
    mcycles(31); chk("timer 63 cycles", int'(data_o), 8'hFF);
    mcycles(1);  chk("timer 64 cycles", int'(data_o), 8'h00);
    chk("timer flag set", int'(timer_flag_o), 1);
    chk("overflow pulse count", ovf_seen, 1);

    // reset mid-count with 0x7A loaded
    data_i = 8'h7A; write_timer_i = 1; st1(3'd0);
    for (int s = 1; s < 5; s++) st1(3'(s));
    mcycles(5);
    chk("pre-reset data", int'(data_o), 8'h7A);
    #3; res_i = 0; model_reset();
    #1;
    chk("mid reset data_o", int'(data_o), 0);
    chk("mid reset flag", int'(timer_flag_o), 0);
    chk("mid reset overflow", int'(overflow_o), 0);
    #2; res_i = 1;
    for (int k = 0; k < 40; k++) mcyc_t1(5'b00001);
    chk("stopped after reset", int'(data_o), 0);

    // counter mode: one edge per machine cycle, then two edges in one
    data_i = 8'h10; write_timer_i = 1; t1_i = 0; st1(3'd0);
    start_cnt_i = 1; st1(3'd1);
    st1(3'd2); st1(3'd3); st1(3'd4);
    for (int k = 0; k < 3; k++) mcyc_t1(5'b00001);
    chk("counter 3 edges", int'(data_o), 8'h13);
    mcyc_t1(5'b01001); chk("counter edge 4", int'(data_o), 8'h14);
    mcyc_t1(5'b00001); chk("counter double edge", int'(data_o), 8'h15);
    mcyc_t1(5'b00000); chk("counter idle", int'(data_o), 8'h15);

    // load in the tick state with prescaler at 31 beats the increment
    data_i = 8'h20; write_timer_i = 1; st1(3'd0);
    st1(3'd1); st1(3'd2); st1(3'd3);
    start_timer_i = 1; st1(3'd4);
    mcycles(31); chk("pre-load data", int'(data_o), 8'h20);
    st1(3'd0); st1(3'd1);
    data_i = 8'h55; write_timer_i = 1; st1(3'd2);
    chk("load beats increment", int'(data_o), 8'h55);
    chk("load no overflow", int'(overflow_o), 0);
    st1(3'd3); st1(3'd4);
    mcycles(31); chk("after load 31", int'(data_o), 8'h55);
    mcycles(1);  chk("after load 32", int'(data_o), 8'h56);

    // overflow coincident with clear_flag keeps the flag
    data_i = 8'hFF; write_timer_i = 1; clear_flag_i = 1; st1(3'd0);
    chk("flag clear", int'(timer_flag_o), 0);
    st1(3'd1); st1(3'd2); st1(3'd3);
    start_timer_i = 1; st1(3'd4);
    mcycles(31);
    st1(3'd0); st1(3'd1);
    clear_flag_i = 1; st1(3'd2);
    chk("set beats clear flag", int'(timer_flag_o), 1);
    chk("set beats clear data", int'(data_o), 0);
    chk("set beats clear pulse", int'(overflow_o), 1);
    clear_flag_i = 1; st1(3'd3);
    chk("later clear", int'(timer_flag_o), 0);
    st1(3'd4);

    // stop holds prescaler at 12; counter mode leaves it alone
    mcycles(12);
    stop_tcnt_i = 1; st1(3'd0);
    chk("prescaler after stop", int'(dut.r_prescaler), 12);
    start_cnt_i = 1; st1(3'd1);
    st1(3'd2); st1(3'd3); st1(3'd4);
    mcycles(3);
    chk("counter no edges", int'(data_o), 0);
    mcyc_t1(5'b00001); mcyc_t1(5'b00001);
    chk("counter two edges", int'(data_o), 2);
    chk("prescaler kept", int'(dut.r_prescaler), 12);

    // randomized run against the model
    ms = 0;
    for (int k = 0; k < 4000; k++) begin
      en_clk_i = ($urandom_range(0, 7) != 0);
      mstate_i = 3'(ms);
      if ($urandom_range(0, 2) == 0) t1_i = ~t1_i;
      write_timer_i = ($urandom_range(0, 39) == 0);
      data_i = ($urandom_range(0, 2) == 0) ? 8'(8'hFF - $urandom_range(0, 3)) : 8'($urandom);
      start_timer_i = ($urandom_range(0, 59) == 0);
      start_cnt_i   = ($urandom_range(0, 59) == 0);
      stop_tcnt_i   = ($urandom_range(0, 99) == 0);
      clear_flag_i  = ($urandom_range(0, 9) == 0);
      if (en_clk_i) ms = (ms + 1) % 5;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
